inputconditioner_multi: RTL and testbench
=========================================

INPUTCONDITIONER_MULTI -- requirements
Module: inputconditioner_multi

Interface
REQ-001 Parameter N, default 4: number of independent input channels, N >= 1.
REQ-002 Parameter T, default 4: debounce length in clk cycles, T >= 1.
REQ-003 Parameter RESET_LEVEL, default {N{1'b0}}: per-channel level loaded on reset.
REQ-004 Port clk  input  1: single clock; all state SHALL update on its rising edge only.
REQ-005 Port rst_n  input  1: reset, synchronous, active-low.
REQ-006 Port pin  input  N: raw asynchronous inputs, one bit per channel.
REQ-007 Port conditioned  output  N: synchronized, debounced level per channel, registered.
REQ-008 Port rising  output  N: one-cycle pulse per channel on a conditioned 0->1 change, registered.
REQ-009 Port falling  output  N: one-cycle pulse per channel on a conditioned 1->0 change, registered.
REQ-010 Port any_edge  output  1: OR-reduction of rising|falling, same cycle, no added register.

Function
REQ-011 Each channel SHALL pass pin[i] through a two-flop synchronizer (sync0 -> sync1) before any other use.
REQ-012 Each channel SHALL own a debounce counter of width max(1,$clog2(T)) that never exceeds T-1.
REQ-013 When sync1[i] == conditioned[i], counter[i] SHALL reset to 0 on the next edge.
REQ-014 When sync1[i] != conditioned[i] and counter[i] < T-1, counter[i] SHALL increment by 1.
REQ-015 When sync1[i] != conditioned[i] and counter[i] == T-1, conditioned[i] SHALL take sync1[i] and counter[i] SHALL return to 0.
REQ-016 Latency: a level held stable on pin[i] SHALL appear on conditioned[i] exactly T+1 cycles after the first clk edge that samples it (T=4: 5 cycles).
REQ-017 A pulse on pin[i] whose synchronized width is shorter than T cycles SHALL leave conditioned[i] unchanged and SHALL produce no rising or falling pulse.
REQ-018 rising[i] and falling[i] SHALL be asserted for exactly one cycle, in the same cycle conditioned[i] changes, and SHALL never be high together.
REQ-019 Channels SHALL be fully independent; simultaneous changes on several channels SHALL each complete per REQ-016 with no interaction.
REQ-020 A pin level returning to conditioned[i] while counting SHALL abandon the count; a later change SHALL restart counting from 0.

Reset
REQ-021 While rst_n is low at a clk edge: sync0, sync1 and conditioned SHALL load RESET_LEVEL; all counters, rising, falling SHALL load 0.
REQ-022 No rising or falling pulse SHALL occur on the cycle after reset release when pin equals RESET_LEVEL.
REQ-023 Reset asserted mid-count SHALL discard the count; the count restarts after release per REQ-016.

Configuration
REQ-024 Macro ICOND_STICKY_EN SHALL, when defined, add port clear  input  N and port flags  output  N (registered).
REQ-025 With ICOND_STICKY_EN: flags[i] SHALL set on the edge after rising[i] or falling[i] is high and clear when clear[i] is high; simultaneous set and clear SHALL leave flags[i] set; reset SHALL clear flags to 0.
REQ-026 Without ICOND_STICKY_EN: ports clear and flags SHALL be absent and no flag state SHALL exist.

Verification
REQ-027 N=4,T=4,RESET_LEVEL=0: pin=4'b0001 held from edge 0 -> conditioned=4'b0001 and rising=4'b0001 for one cycle at edge 5; any_edge high that cycle only.
REQ-028 pin[0] high for 3 sampled cycles then low -> conditioned[0] stays 0, rising/falling stay 0.
REQ-029 pin=4'b1111 then 4'b0000 after 10 cycles -> falling=4'b1111 for one cycle 5 cycles after the change.
REQ-030 rst_n low at edge 3 during a count, released at edge 5, pin stable -> conditioned changes 5 cycles after the first post-release sampling edge.
REQ-031 RESET_LEVEL=4'b1010, pin=4'b1010 through release -> no rising/falling pulse, conditioned=4'b1010 throughout.
REQ-032 ICOND_STICKY_EN: rising[2] pulse with clear[2] high the same cycle -> flags[2]=1; clear[2] high next cycle -> flags[2]=0.

Source files
------------

// File: rtl/inputconditioner_multi_if.sv
// -----------------------------------------------------------------------------
// inputconditioner_multi_if
// Bundles the per-channel signals of inputconditioner_multi.
//   pin          raw asynchronous inputs, one bit per channel
//   conditioned  synchronized, debounced level per channel
//   rising       one-cycle pulse on a conditioned 0->1 change
//   falling      one-cycle pulse on a conditioned 1->0 change
//   any_edge     OR of all rising/falling bits
//   clear, flags sticky edge flags and their clear (only with ICOND_STICKY_EN)
// Modports: master = the side that drives pin (and clear), slave = the conditioner.
// -----------------------------------------------------------------------------
interface inputconditioner_multi_if #(
   parameter int N = 4
) ();
   logic [N-1:0] pin;
   logic [N-1:0] conditioned;
   logic [N-1:0] rising;
   logic [N-1:0] falling;
   logic         any_edge;
`ifdef ICOND_STICKY_EN
   logic [N-1:0] clear;
   logic [N-1:0] flags;

   modport master (output pin, clear,
                   input  conditioned, rising, falling, any_edge, flags);
   modport slave  (input  pin, clear,
                   output conditioned, rising, falling, any_edge, flags);
`else
   modport master (output pin,
                   input  conditioned, rising, falling, any_edge);
   modport slave  (input  pin,
                   output conditioned, rising, falling, any_edge);
`endif
endinterface

// File: rtl/inputconditioner_multi.sv
// -----------------------------------------------------------------------------
// inputconditioner_multi
// N independent input channels. Each raw pin is passed through a two-flop
// synchronizer and then debounced: a new level must be seen on the
// synchronizer output for T consecutive cycles before the conditioned output
// follows it. Registered one-cycle rising/falling pulses mark each change.
//
// Parameters: N (channels), T (debounce cycles), RESET_LEVEL (per-channel
//             level loaded into the synchronizer and the conditioned output).
// Ports:
//   clk    clock, all state on the rising edge
//   rst_n  synchronous active-low reset
//   bus    inputconditioner_multi_if.slave: pin in; conditioned, rising,
//          falling, any_edge out (clear in / flags out with ICOND_STICKY_EN)
// Option: define ICOND_STICKY_EN to add per-channel sticky edge flags that
//         hold until cleared; clear and flags exist only in that build.
// -----------------------------------------------------------------------------
module inputconditioner_multi #(
   parameter int           N           = 4,
   parameter int           T           = 4,
   parameter logic [N-1:0] RESET_LEVEL = {N{1'b0}}
) (
   input  logic                          clk,
   input  logic                          rst_n,
   inputconditioner_multi_if.slave       bus
);

   localparam int            CW      = (T > 1) ? $clog2(T) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(T - 1);

   logic [N-1:0]  sync0;
   logic [N-1:0]  sync1;
   logic [N-1:0]  conditioned;
   logic [N-1:0]  rising;
   logic [N-1:0]  falling;
   logic [CW-1:0] counter  [N];

   logic [N-1:0]  cond_next;
   logic [CW-1:0] cnt_next [N];

   // Debounce decision per channel. The counter only runs while the
   // synchronized input disagrees with the conditioned level; any agreement
   // (including a glitch going away) drops it back to 0.
   always_comb begin
      // NOTE: every output gets a default before the loop, so no path leaves
      // a value unassigned and no latch is inferred.
      cond_next = conditioned;
      cnt_next  = '{default: '0};
      for (int i = 0; i < N; i++) begin
         if (sync1[i] != conditioned[i]) begin
            if (counter[i] == CNT_MAX) begin
               cond_next[i] = sync1[i];
            end else begin
               cnt_next[i] = counter[i] + 1'b1;
            end
         end
      end
   end

   // NOTE: state is updated with non-blocking assignments only, so each flop
   // samples the pre-edge value of the others (the synchronizer chain relies
   // on this).
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync0       <= RESET_LEVEL;
         sync1       <= RESET_LEVEL;
         conditioned <= RESET_LEVEL;
         rising      <= '0;
         falling     <= '0;
         // NOTE: the counters are a small register array, not a RAM, so they
         // are reset explicitly; an in-flight count must not survive reset.
         counter     <= '{default: '0};
      end else begin
         sync0       <= bus.pin;
         sync1       <= sync0;
         conditioned <= cond_next;
         // Pulses are registered alongside the level change so they line up
         // with the cycle in which conditioned switches.
         rising      <= cond_next & ~conditioned;
         falling     <= ~cond_next & conditioned;
         counter     <= cnt_next;
      end
   end

   assign bus.conditioned = conditioned;
   assign bus.rising      = rising;
   assign bus.falling     = falling;
   assign bus.any_edge    = |(rising | falling);

`ifdef ICOND_STICKY_EN
   logic [N-1:0] flags;

   // Set wins over clear: a pulse arriving while software clears is not lost.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         flags <= '0;
      end else begin
         flags <= (flags & ~bus.clear) | rising | falling;
      end
   end

   assign bus.flags = flags;
`endif

endmodule

// File: tb/tb_inputconditioner_multi.sv
// -----------------------------------------------------------------------------
// tb_inputconditioner_multi
// Directed bench for inputconditioner_multi (N=4, T=4). Instance a uses
// RESET_LEVEL=0 and carries the functional sequences; instance b uses
// RESET_LEVEL=4'b1010 with its pins held at that level throughout.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_inputconditioner_multi;

   logic clk = 1'b0;
   logic rst_n;

   int checks   = 0;
   int failures = 0;

   inputconditioner_multi_if #(.N(4)) ifa ();
   inputconditioner_multi_if #(.N(4)) ifb ();

   inputconditioner_multi #(
      .N(4), .T(4), .RESET_LEVEL(4'b0000)
   ) u_dut_a (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (ifa)
   );

   inputconditioner_multi #(
      .N(4), .T(4), .RESET_LEVEL(4'b1010)
   ) u_dut_b (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (ifb)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // One rising edge, then settle before driving or sampling.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n   = 1'b0;
      ifa.pin = 4'b0000;
      ifb.pin = 4'b1010;
`ifdef ICOND_STICKY_EN
      ifa.clear = 4'b0000;
      ifb.clear = 4'b0000;
`endif

      // Reset state on both instances.
      repeat (3) step();
      check("rst_cond_a",  {28'd0, ifa.conditioned}, 32'h0);
      check("rst_pulse_a", {23'd0, ifa.rising, ifa.falling, ifa.any_edge}, 32'h0);
      check("rst_cond_b",  {28'd0, ifb.conditioned}, 32'ha);
      check("rst_pulse_b", {23'd0, ifb.rising, ifb.falling, ifb.any_edge}, 32'h0);
`ifdef ICOND_STICKY_EN
      check("rst_flags_a", {28'd0, ifa.flags}, 32'h0);
`endif

      // Release with pins at reset level: no pulses, levels unchanged.
      rst_n = 1'b1;
      for (int e = 0; e < 6; e++) begin
         step();
         check("rel_a", {19'd0, ifa.conditioned, ifa.rising, ifa.falling, ifa.any_edge}, 32'h0);
         check("rel_b", {19'd0, ifb.conditioned, ifb.rising, ifb.falling, ifb.any_edge}, 32'h1400);
      end

      // Glitch: pin[0] high for 3 sampled edges, then low.
      ifa.pin = 4'b0001;
      repeat (3) step();
      ifa.pin = 4'b0000;
      for (int e = 0; e < 8; e++) begin
         step();
         check("glitch", {20'd0, ifa.conditioned, ifa.rising, ifa.falling}, 32'h0);
      end

      // Latency: pin[0] held high from edge 0, appears at edge 5.
      ifa.pin = 4'b0001;
      for (int e = 0; e < 7; e++) begin
         step();
         if (e < 5) begin
            check("lat_wait", {28'd0, ifa.conditioned}, 32'h0);
         end else if (e == 5) begin
            check("lat_cond",    {28'd0, ifa.conditioned}, 32'h1);
            check("lat_rise",    {28'd0, ifa.rising},      32'h1);
            check("lat_fall",    {28'd0, ifa.falling},     32'h0);
            check("lat_any",     {31'd0, ifa.any_edge},    32'h1);
         end else begin
            check("lat_rise_end", {28'd0, ifa.rising},   32'h0);
            check("lat_any_end",  {31'd0, ifa.any_edge}, 32'h0);
            check("lat_hold",     {28'd0, ifa.conditioned}, 32'h1);
         end
      end

      // All high, then all low: falling on all channels 5 edges after change.
      ifa.pin = 4'b1111;
      repeat (10) step();
      check("all_high", {28'd0, ifa.conditioned}, 32'hf);
      ifa.pin = 4'b0000;
      for (int e = 0; e < 7; e++) begin
         step();
         if (e == 4) begin
            check("fall_early", {24'd0, ifa.conditioned, ifa.falling}, 32'hf0);
         end else if (e == 5) begin
            check("fall_cond",  {28'd0, ifa.conditioned}, 32'h0);
            check("fall_pulse", {28'd0, ifa.falling},     32'hf);
            check("fall_norise", {28'd0, ifa.rising},     32'h0);
         end else if (e == 6) begin
            check("fall_end", {28'd0, ifa.falling}, 32'h0);
         end
      end

      // Independence: channels 0,1 change at edge 0, channel 2 at edge 2.
      ifa.pin = 4'b0011;
      for (int e = 0; e < 8; e++) begin
         step();
         if (e == 1) ifa.pin = 4'b0111;
         if (e == 4) begin
            check("ind_wait", {28'd0, ifa.conditioned}, 32'h0);
         end else if (e == 5) begin
            check("ind_cond01", {28'd0, ifa.conditioned}, 32'h3);
            check("ind_rise01", {28'd0, ifa.rising},      32'h3);
         end else if (e == 6) begin
            check("ind_gap", {24'd0, ifa.conditioned, ifa.rising}, 32'h30);
         end else if (e == 7) begin
            check("ind_cond2", {28'd0, ifa.conditioned}, 32'h7);
            check("ind_rise2", {28'd0, ifa.rising},      32'h4);
         end
      end

      // Abandoned count: pin[3] high 3 edges, low 1 edge, then held high.
      // The held level must take the full 5 edges from its own start.
      ifa.pin = 4'b1111;
      repeat (3) step();
      ifa.pin = 4'b0111;
      step();
      ifa.pin = 4'b1111;
      for (int e = 0; e < 6; e++) begin
         step();
         if (e == 4) begin
            check("abn_wait", {28'd0, ifa.conditioned}, 32'h7);
         end else if (e == 5) begin
            check("abn_cond", {28'd0, ifa.conditioned}, 32'hf);
            check("abn_rise", {28'd0, ifa.rising},      32'h8);
         end
      end

      // Reset mid-count: edges 3,4 in reset, edge 5 first sampling edge,
      // change expected at edge 10.
      ifa.pin = 4'b0000;
      repeat (10) step();
      check("pre_rst_low", {28'd0, ifa.conditioned}, 32'h0);
      ifa.pin = 4'b1111;
      repeat (3) step();
      rst_n = 1'b0;
      step();
      check("mid_rst_a", {20'd0, ifa.conditioned, ifa.rising, ifa.falling}, 32'h0);
      check("mid_rst_b", {28'd0, ifb.conditioned}, 32'ha);
      step();
      rst_n = 1'b1;
      for (int e = 5; e < 12; e++) begin
         step();
         check("mid_rst_b_quiet", {23'd0, ifb.rising, ifb.falling, ifb.any_edge}, 32'h0);
         if (e == 9) begin
            check("mid_rst_wait", {28'd0, ifa.conditioned}, 32'h0);
         end else if (e == 10) begin
            check("mid_rst_cond", {28'd0, ifa.conditioned}, 32'hf);
            check("mid_rst_rise", {28'd0, ifa.rising},      32'hf);
         end
      end

`ifdef ICOND_STICKY_EN
      // Sticky flags: set wins over a simultaneous clear, clear next cycle.
      ifa.pin = 4'b1011;
      repeat (8) step();
      ifa.clear = 4'b1111;
      step();
      ifa.clear = 4'b0000;
      check("flag_cleared", {28'd0, ifa.flags}, 32'h0);
      ifa.pin = 4'b1111;
      for (int e = 0; e < 6; e++) step();
      check("flag_rise2", {28'd0, ifa.rising}, 32'h4);
      ifa.clear = 4'b0100;
      step();
      check("flag_set_wins", {28'd0, ifa.flags}, 32'h4);
      step();
      check("flag_clear", {28'd0, ifa.flags}, 32'h0);
      ifa.clear = 4'b0000;
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
